// File: rtl/brush_stamp_engine_if.sv
// Command handshake and frame-buffer write port for brush_stamp_engine.
// The master side is the command source or arbiter; the slave side is the engine.
interface brush_stamp_engine_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 15
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [7:0]         cmd_x;
  logic [6:0]         cmd_y;
  logic [3:0]         cmd_size;
  logic [COLOR_W-1:0] cmd_color;
  logic               gnt;
  logic               we;
  logic [ADDR_W-1:0]  a;
  logic [COLOR_W-1:0] wd;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_size, cmd_color, gnt,
    input  cmd_ready, we, a, wd, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_size, cmd_color, gnt,
    output cmd_ready, we, a, wd, busy, done
  );
endinterface

// File: rtl/brush_stamp_engine.sv
// Expands stamp/clear paint commands into a stream of single-pixel frame-buffer writes.
// The write port is shared through a per-cycle grant.
module brush_stamp_engine #(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int COLOR_W   = 12,
  parameter int ADDR_W    = 15,
  parameter int MAX_BRUSH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  brush_stamp_engine_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;

  state_t             state, state_next;
  logic [7:0]         col, x_start, x_end;
  logic [6:0]         row, y_end;
  logic [COLOR_W-1:0] color;
  logic               done_q;

  logic [3:0]         size_eff;
  logic [8:0]         x_end_raw, y_end_raw;
  logic [7:0]         x_end_clip;
  logic [6:0]         y_end_clip;
  logic               empty, ready, accept, we_int, last_px;
  logic [ADDR_W-1:0]  row_ext;

  // Clipped rectangle bounds, computed in 9 bits so nothing wraps.
  always_comb begin
    size_eff = bus.cmd_size;
    if (bus.cmd_size == '0)
      size_eff = 4'd1;
    else if (bus.cmd_size > 4'(MAX_BRUSH))
      size_eff = 4'(MAX_BRUSH);
    x_end_raw  = {1'b0, bus.cmd_x} + 9'(size_eff) - 9'd1;
    y_end_raw  = {2'b00, bus.cmd_y} + 9'(size_eff) - 9'd1;
    x_end_clip = (x_end_raw > 9'(H_RES - 1)) ? 8'(H_RES - 1) : x_end_raw[7:0];
    y_end_clip = (y_end_raw > 9'(V_RES - 1)) ? 7'(V_RES - 1) : y_end_raw[6:0];
    empty      = ({1'b0, bus.cmd_x} >= 9'(H_RES)) || ({1'b0, bus.cmd_y} >= 8'(V_RES));
  end

  always_comb begin
    state_next = state;
    ready      = (state == IDLE) && !reset;
    accept     = bus.cmd_valid && ready;
    we_int     = (state != IDLE) && bus.gnt && !reset;
    last_px    = (col == x_end) && (row == y_end);
    case (state)
      IDLE: begin
        if (accept && bus.cmd_op)
          state_next = CLEAR;
        else if (accept && !empty)
          state_next = STAMP;
      end
      STAMP, CLEAR: begin
        if (we_int && last_px)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A clear is a full-screen stamp, so both ops share the same raster walker.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      color   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        color <= bus.cmd_color;
        if (bus.cmd_op) begin
          x_start <= '0;
          col     <= '0;
          row     <= '0;
          x_end   <= 8'(H_RES - 1);
          y_end   <= 7'(V_RES - 1);
        end else if (!empty) begin
          x_start <= bus.cmd_x;
          col     <= bus.cmd_x;
          row     <= bus.cmd_y;
          x_end   <= x_end_clip;
          y_end   <= y_end_clip;
        end else begin
          done_q  <= 1'b1;
        end
      end else if (we_int) begin
        if (last_px) begin
          done_q <= 1'b1;
        end else if (col == x_end) begin
          col <= x_start;
          row <= row + 7'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

  assign row_ext       = ADDR_W'(row);
  assign bus.cmd_ready = ready;
  assign bus.we        = we_int;
  assign bus.a         = (row_ext << 7) + (row_ext << 5) + ADDR_W'(col);
  assign bus.wd        = color;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_brush_stamp_engine.sv
// Bench for brush_stamp_engine: directed and random paint commands checked against
// a queue of expected pixel addresses built from the clipping rules.
module tb_brush_stamp_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  brush_stamp_engine_if #(.COLOR_W(12), .ADDR_W(15)) bif();

  brush_stamp_engine #(
    .H_RES(160), .V_RES(120), .COLOR_W(12), .ADDR_W(15), .MAX_BRUSH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];
  int gpat[$];

  // Reference: list every pixel address the command should write, in order.
  function automatic void build_exp(input bit op, input int x, input int y, input int size);
    int s, xe, ye;
    exp_q.delete();
    if (op) begin
      for (int i = 0; i < 160 * 120; i++) exp_q.push_back(i);
      return;
    end
    s = (size == 0) ? 1 : (size > 8 ? 8 : size);
    if (x >= 160 || y >= 120) return;
    xe = (x + s - 1 > 159) ? 159 : x + s - 1;
    ye = (y + s - 1 > 119) ? 119 : y + s - 1;
    for (int r = y; r <= ye; r++)
      for (int c = x; c <= xe; c++)
        exp_q.push_back(r * 160 + c);
  endfunction

  task automatic send_cmd(input bit op, input int x, input int y, input int size,
                          input logic [11:0] color);
    bit ok = 0;
    bif.cmd_op    = op;
    bif.cmd_x     = x[7:0];
    bif.cmd_y     = y[6:0];
    bif.cmd_size  = size[3:0];
    bif.cmd_color = color;
    bif.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bif.cmd_ready === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    bif.cmd_valid = 1'b0;
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept: cmd_ready got 0 for 50 cycles, expected 1");
    end
  endtask

  // Walk the expected queue cycle by cycle; gmode 0 = gnt high, 1 = random, 2 = gpat.
  task automatic stream(input string name, input logic [11:0] color, input int gmode,
                        input int stop_after, input bit chain, input int nx, input int ny,
                        input int nsize, input logic [11:0] ncolor);
    int pi = 0;
    int writes = 0;
    bit g;
    bit fin = 0;
    while (!fin) begin
      if (exp_q.size() > 0) begin
        case (gmode)
          0:       g = 1'b1;
          1:       g = 1'($urandom_range(0, 1));
          default: g = (gpat[pi % gpat.size()] != 0);
        endcase
        pi++;
        bif.gnt = g;
        @(negedge clk);
        tests_run++;
        if (bif.we !== g) begin
          tests_failed++;
          $display("FAIL %s we: got %b expected %b", name, bif.we, g);
        end
        tests_run++;
        if (bif.a !== 15'(exp_q[0])) begin
          tests_failed++;
          $display("FAIL %s addr: got %0d expected %0d", name, bif.a, exp_q[0]);
        end
        tests_run++;
        if (bif.wd !== color) begin
          tests_failed++;
          $display("FAIL %s wd: got %h expected %h", name, bif.wd, color);
        end
        tests_run++;
        if ({bif.busy, bif.done} !== 2'b10) begin
          tests_failed++;
          $display("FAIL %s busy/done: got %b expected 10", name, {bif.busy, bif.done});
        end
        if (g) begin
          void'(exp_q.pop_front());
          writes++;
        end
        @(posedge clk); #1;
        if (stop_after > 0 && writes == stop_after) fin = 1;
      end else begin
        bif.gnt = 1'($urandom_range(0, 1));
        if (chain) begin
          bif.cmd_op    = 1'b0;
          bif.cmd_x     = nx[7:0];
          bif.cmd_y     = ny[6:0];
          bif.cmd_size  = nsize[3:0];
          bif.cmd_color = ncolor;
          bif.cmd_valid = 1'b1;
        end
        @(negedge clk);
        tests_run++;
        if ({bif.done, bif.busy, bif.we, bif.cmd_ready} !== 4'b1001) begin
          tests_failed++;
          $display("FAIL %s completion done/busy/we/ready: got %b expected 1001", name,
                   {bif.done, bif.busy, bif.we, bif.cmd_ready});
        end
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if ({bif.we, bif.busy, bif.done, bif.cmd_ready} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset we/busy/done/ready: got %b expected 0000",
                 {bif.we, bif.busy, bif.done, bif.cmd_ready});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bif.cmd_ready, bif.busy, bif.done, bif.we} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL release ready/busy/done/we: got %b expected 1000",
               {bif.cmd_ready, bif.busy, bif.done, bif.we});
    end
    tests_run++;
    if ({bif.a, bif.wd} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset a/wd: got %0d/%h expected 0/000", bif.a, bif.wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stamp(input string name, input int x, input int y, input int size,
                            input logic [11:0] color, input int gmode);
    send_cmd(1'b0, x, y, size, color);
    build_exp(1'b0, x, y, size);
    stream(name, color, gmode, 0, 1'b0, 0, 0, 0, 12'h000);
  endtask

  task automatic test_gnt_pattern();
    gpat = '{1, 0, 0, 1, 1, 0, 1};
    test_stamp("gnt_pattern", 0, 0, 2, 12'h0A5, 2);
  endtask

  task automatic test_clear();
    send_cmd(1'b1, 0, 0, 0, 12'h000);
    build_exp(1'b1, 0, 0, 0);
    stream("clear", 12'h000, 0, 0, 1'b0, 0, 0, 0, 12'h000);
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 0, 0, 0, 12'hABC);
    build_exp(1'b1, 0, 0, 0);
    stream("clear_abort", 12'hABC, 0, 500, 1'b0, 0, 0, 0, 12'h000);
    reset = 1'b1;
    bif.gnt = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bif.we !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset we: got %b expected 0", bif.we);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({bif.busy, bif.done, bif.we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset busy/done/we: got %b expected 000", {bif.busy, bif.done, bif.we});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bif.cmd_ready, bif.done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_reset release ready/done: got %b expected 10", {bif.cmd_ready, bif.done});
    end
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b0, 5, 5, 2, 12'h123);
    build_exp(1'b0, 5, 5, 2);
    stream("b2b_first", 12'h123, 0, 0, 1'b1, 20, 30, 3, 12'h456);
    build_exp(1'b0, 20, 30, 3);
    stream("b2b_second", 12'h456, 0, 0, 1'b0, 0, 0, 0, 12'h000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      test_stamp("random", int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 15)), 12'($urandom), int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = 1'b0;
    bif.cmd_x     = '0;
    bif.cmd_y     = '0;
    bif.cmd_size  = '0;
    bif.cmd_color = '0;
    bif.gnt       = 1'b0;
    test_reset();
    test_stamp("basic", 10, 20, 3, 12'hF00, 0);
    test_stamp("clip", 158, 118, 4, 12'h0F0, 0);
    test_stamp("empty", 160, 5, 3, 12'h00F, 0);
    test_stamp("size0", 0, 0, 0, 12'h777, 0);
    test_stamp("size12", 0, 0, 12, 12'h3C3, 0);
    test_gnt_pattern();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
